// File: rtl/ir_sample_filter_if.sv
// rtl/ir_sample_filter_if.sv - sample stream in, filtered average stream out
interface ir_sample_filter_if #(
   parameter int DATA_WIDTH = 16
);
   logic                         sample_valid;
   logic signed [DATA_WIDTH-1:0] sample_in;
   logic signed [DATA_WIDTH-1:0] avg_out;
   logic                         avg_valid;
   logic                         primed;

   // producer side: ADC FSM / testbench
   modport master (
      output sample_valid, sample_in,
      input  avg_out, avg_valid, primed
   );

   // filter side
   modport slave (
      input  sample_valid, sample_in,
      output avg_out, avg_valid, primed
   );
endinterface

// File: rtl/ir_sample_filter.sv
// rtl/ir_sample_filter.sv - primed sliding-window moving average; IR_FILTER_MEDIAN3_EN adds a median-of-3 pre-stage
module ir_sample_filter #(
   parameter int DATA_WIDTH = 16,
   parameter int WIN_POW2   = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              clear,
   ir_sample_filter_if.slave bus
);
   localparam int DEPTH = 1 << WIN_POW2;
   localparam int SUM_W = DATA_WIDTH + WIN_POW2;

   typedef enum logic {ST_PRIME, ST_RUN} state_t;

   state_t                       state_q, state_d;
   logic signed [DATA_WIDTH-1:0] win_buf [DEPTH];
   logic [WIN_POW2-1:0]          wr_ptr;
   logic signed [SUM_W-1:0]      sum_q, sum_d;
   logic signed [DATA_WIDTH-1:0] x_eff;
   logic signed [DATA_WIDTH-1:0] avg_q;
   logic                         avg_valid_q;
   logic                         accept;
   logic                         priming;

   // clear beats a coincident sample: that sample is dropped
   assign accept  = bus.sample_valid & ~clear;
   assign priming = (state_q == ST_PRIME);

`ifdef IR_FILTER_MEDIAN3_EN
   logic signed [DATA_WIDTH-1:0] hist1, hist2;
   logic signed [DATA_WIDTH-1:0] lo_ab, hi_ab, mid_c;

   // median(x, h1, h2) = max(min(x,h1), min(max(x,h1), h2)); a prime passes x straight through
   always_comb begin
      lo_ab = (bus.sample_in < hist1) ? bus.sample_in : hist1;
      hi_ab = (bus.sample_in < hist1) ? hist1 : bus.sample_in;
      mid_c = (hi_ab < hist2) ? hi_ab : hist2;
      x_eff = priming ? bus.sample_in : ((lo_ab > mid_c) ? lo_ab : mid_c);
   end

   // raw-sample history; loaded with x on the priming sample
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist1 <= '0;
         hist2 <= '0;
      end else if (accept) begin
         if (priming) begin
            hist1 <= bus.sample_in;
            hist2 <= bus.sample_in;
         end else begin
            hist1 <= bus.sample_in;
            hist2 <= hist1;
         end
      end
   end
`else
   assign x_eff = bus.sample_in;
`endif

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_PRIME;
      else          state_q <= state_d;
   end

   // next state: any accepted sample in PRIME primes the window; clear always re-primes
   always_comb begin
      state_d = state_q;
      if (clear)                  state_d = ST_PRIME;
      else if (accept && priming) state_d = ST_RUN;
   end

   // next running sum: a prime seeds the whole window with x, otherwise swap oldest for newest
   always_comb begin
      sum_d = sum_q;
      if (priming) sum_d = SUM_W'(x_eff) <<< WIN_POW2;
      else         sum_d = sum_q + SUM_W'(x_eff) - SUM_W'(win_buf[wr_ptr]);
   end

   // window storage
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) win_buf[i] <= '0;
      end else if (accept) begin
         if (priming) begin
            for (int i = 0; i < DEPTH; i++) win_buf[i] <= x_eff;
         end else begin
            win_buf[wr_ptr] <= x_eff;
         end
      end
   end

   // write pointer and running sum
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         sum_q  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
      end else if (accept) begin
         wr_ptr <= priming ? WIN_POW2'(1) : wr_ptr + WIN_POW2'(1);
         sum_q  <= sum_d;
      end
   end

   // output register: the upper DATA_WIDTH bits of the sum are the floored mean
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         avg_q       <= '0;
         avg_valid_q <= 1'b0;
      end else begin
         avg_valid_q <= accept;
         if (accept) avg_q <= sum_d[SUM_W-1:WIN_POW2];
      end
   end

   assign bus.avg_out   = avg_q;
   assign bus.avg_valid = avg_valid_q;
   assign bus.primed    = (state_q == ST_RUN);
endmodule

// File: tb/tb_ir_sample_filter.sv
// tb/tb_ir_sample_filter.sv - scoreboard bench for ir_sample_filter against a window-queue model
module tb_ir_sample_filter;
   localparam int DW = 16;
   localparam int WP = 2;
   localparam int N  = 1 << WP;
`ifdef IR_FILTER_MEDIAN3_EN
   localparam bit MED = 1'b1;
`else
   localparam bit MED = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n;
   logic clear;

   ir_sample_filter_if #(.DATA_WIDTH(DW)) bus ();

   ir_sample_filter #(.DATA_WIDTH(DW), .WIN_POW2(WP)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int val;
      int at;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // reference model state
   int win[$];
   bit m_primed = 1'b0;
   int h1 = 0;
   int h2 = 0;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   function automatic int floor_div(input int s, input int d);
      int q;
      q = s / d;
      if ((s % d != 0) && (s < 0)) q = q - 1;
      return q;
   endfunction

   function automatic int median3(input int a, input int b, input int c);
      int t[3];
      int tmp;
      t[0] = a; t[1] = b; t[2] = c;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2 - i; j++)
            if (t[j] > t[j+1]) begin
               tmp = t[j]; t[j] = t[j+1]; t[j+1] = tmp;
            end
      return t[1];
   endfunction

   function automatic int model_accept(input int x);
      int v;
      int s;
      if (!m_primed) begin
         v = x;
         h1 = x;
         h2 = x;
         win.delete();
         for (int i = 0; i < N; i++) win.push_back(v);
         m_primed = 1'b1;
      end else begin
         v = MED ? median3(x, h1, h2) : x;
         h2 = h1;
         h1 = x;
         void'(win.pop_front());
         win.push_back(v);
      end
      s = 0;
      foreach (win[i]) s += win[i];
      return floor_div(s, N);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      chk("primed", int'(bus.primed), int'(m_primed));
   endtask

   // one cycle of stimulus; use_c selects a hand-derived expectation over the model's
   task automatic drive(input bit v, input bit c, input int x, input bit use_c, input int cexp);
      exp_t e;
      int   m;
      bus.sample_valid = v;
      bus.sample_in    = DW'(x);
      clear            = c;
      if (c) begin
         m_primed = 1'b0;
      end else if (v) begin
         m = model_accept(x);
         e.val = use_c ? cexp : m;
         e.at  = cyc + 1;
         exp_q.push_back(e);
      end
      tick();
      bus.sample_valid = 1'b0;
      clear            = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 1'b0, 0);
   endtask

   function automatic int rand_sample();
      int r;
      r = int'($urandom_range(0, 7));
      if (r == 0) return -32768;
      if (r == 1) return 32767;
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   // scoreboard monitor: pops on every avg_valid, checks latency and hold behaviour
   logic signed [DW-1:0] last_out = '0;
   always @(negedge clk) begin
      if (reset_n !== 1'b1) begin
         last_out = '0;
      end else begin
         while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            exp_t lost;
            lost = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_avg_valid got none expected %0d due cycle %0d", lost.val, lost.at);
         end
         if (bus.avg_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_avg_valid got avg_out %0d expected no strobe (cycle %0d)", bus.avg_out, cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("avg_out", int'(bus.avg_out), e.val);
               chk("avg_latency", cyc, e.at);
            end
            last_out = bus.avg_out;
         end else begin
            chk("avg_hold", int'(bus.avg_out), int'(last_out));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n          = 1'b0;
      clear            = 1'b0;
      bus.sample_valid = 1'b0;
      bus.sample_in    = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_avg_out", int'(bus.avg_out), 0);
      chk("reset_avg_valid", int'(bus.avg_valid), 0);
      chk("reset_primed", int'(bus.primed), 0);
      reset_n = 1'b1;
      idle(2);

      // prime and back-to-back ramp
      drive(1'b1, 1'b0, 1000, 1'b1, 1000);
      drive(1'b1, 1'b0, 2000, !MED, 1250);
      drive(1'b1, 1'b0, 2000, !MED, 1500);
      drive(1'b1, 1'b0, 2000, !MED, 1750);
      drive(1'b1, 1'b0, 2000, !MED, 2000);
      idle(3);

      // floor toward minus infinity
      drive(1'b0, 1'b1, 0, 1'b0, 0);
      drive(1'b1, 1'b0, -1, 1'b1, -1);
      drive(1'b1, 1'b0, 0, 1'b1, -1);
      idle(2);

      // extremes held for a full window
      drive(1'b0, 1'b1, 0, 1'b0, 0);
      for (int i = 0; i < N; i++) drive(1'b1, 1'b0, -32768, 1'b1, -32768);
      drive(1'b0, 1'b1, 0, 1'b0, 0);
      for (int i = 0; i < N; i++) drive(1'b1, 1'b0, 32767, 1'b1, 32767);
      idle(2);

      // clear coincident with sample_valid drops the sample
      for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, rand_sample(), 1'b0, 0);
      drive(1'b1, 1'b1, 1234, 1'b0, 0);
      idle(1);
      drive(1'b1, 1'b0, 500, 1'b1, 500);
      idle(2);

      // asynchronous reset mid-stream while a strobe is showing
      drive(1'b1, 1'b0, 3000, 1'b0, 0);
      reset_n = 1'b0;
      exp_q.delete();
      m_primed = 1'b0;
      #1;
      chk("midreset_avg_out", int'(bus.avg_out), 0);
      chk("midreset_avg_valid", int'(bus.avg_valid), 0);
      chk("midreset_primed", int'(bus.primed), 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      idle(1);
      drive(1'b1, 1'b0, 700, 1'b1, 700);
      idle(2);

      // spike handling
      drive(1'b0, 1'b1, 0, 1'b0, 0);
      drive(1'b1, 1'b0, 1000, 1'b1, 1000);
      drive(1'b1, 1'b0, 1000, 1'b1, 1000);
      drive(1'b1, 1'b0, 9000, 1'b1, MED ? 1000 : 3000);
      drive(1'b1, 1'b0, 1000, 1'b1, MED ? 1000 : 3000);
      idle(2);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         bit v;
         bit c;
         v = ($urandom_range(0, 9) < 7);
         c = ($urandom_range(0, 39) == 0);
         drive(v, c, rand_sample(), 1'b0, 0);
      end
      idle(4);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
